sync_fifo: RTL and testbench

//   Single-clock first-word-fall-through FIFO. It buffers 32-bit accelerator instruction words

---
 rtl/sync_fifo.sv | 138 +++++++++++++
 tb/tb_sync_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//
// Buffers accelerator instruction words between a producer (push side) and a
// consumer (pop side). The head entry is always driven on r_data. This lets the
// consumer inspect a word before it pops it.
//
// Parameters
//   WIDTH  data word width in bits (>= 1)
//   DEPTH  number of storage entries (>= 2, need not be a power of two)
//
// Ports
//   aclk     in   clock, rising edge
//   aresetn  in   asynchronous active-low reset
//   w_en     in   push request
//   w_data   in   push data
//   r_en     in   pop request
//   r_data   out  head-of-queue word; stale while empty
//   full     out  DEPTH entries held (registered)
//   empty    out  no entries held (registered)
//   count    out  current occupancy
//   err_ovf  out  sticky: push attempted while full     (SYNC_FIFO_ERR_EN only)
//   err_udf  out  sticky: pop attempted while empty     (SYNC_FIFO_ERR_EN only)
//
// Optional feature macro: SYNC_FIFO_ERR_EN adds the sticky error flags.

module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             w_en,
    input  logic [WIDTH-1:0] w_data,
    input  logic             r_en,
    output logic [WIDTH-1:0] r_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic             err_ovf,
    output logic             err_udf
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    logic push;
    logic pop;

    // Acceptance uses only the registered flags, so a push into a full FIFO is
    // dropped even when a pop happens on the same edge.
    assign push = w_en & ~full_q;
    assign pop  = r_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Explicit wrap compare, since DEPTH may not be a power of two.
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr_q] <= w_data;
        end
    end

    assign r_data = mem[rd_ptr_q];
    assign full   = full_q;
    assign empty  = empty_q;
    assign count  = count_q;

`ifdef SYNC_FIFO_ERR_EN
    logic err_ovf_q;
    logic err_udf_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (w_en && full_q) begin
                err_ovf_q <= 1'b1;
            end
            if (r_en && empty_q) begin
                err_udf_q <= 1'b1;
            end
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo. Directed scenarios plus a
// randomized run, all compared against a queue-based reference model.

module tb_sync_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             aclk;
    logic             aresetn;
    logic             w_en;
    logic [WIDTH-1:0] w_data;
    logic             r_en;
    logic [WIDTH-1:0] r_data;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
`ifdef SYNC_FIFO_ERR_EN
    logic             err_ovf;
    logic             err_udf;
`endif

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .w_en    (w_en),
        .w_data  (w_data),
        .r_en    (r_en),
        .r_data  (r_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_ovf (err_ovf),
        .err_udf (err_udf)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue plus sticky error bits.
    logic [WIDTH-1:0] model[$];
    bit               ovf_m;
    bit               udf_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".count"}, 64'(count), 64'(model.size()));
        check({tag, ".empty"}, 64'(empty), 64'(model.size() == 0));
        check({tag, ".full"},  64'(full),  64'(model.size() == DEPTH));
        if (model.size() != 0) begin
            check({tag, ".r_data"}, 64'(r_data), 64'(model[0]));
        end
`ifdef SYNC_FIFO_ERR_EN
        check({tag, ".err_ovf"}, 64'(err_ovf), 64'(ovf_m));
        check({tag, ".err_udf"}, 64'(err_udf), 64'(udf_m));
`endif
    endtask

    // One clock cycle of stimulus, model update at the edge, check 1 ns later.
    task automatic step(input string tag, input logic w, input logic [WIDTH-1:0] d,
                        input logic r);
        bit full_b;
        bit empty_b;
        @(negedge aclk);
        w_en   = w;
        w_data = d;
        r_en   = r;
        @(posedge aclk);
        full_b  = (model.size() == DEPTH);
        empty_b = (model.size() == 0);
        if (w && full_b)  ovf_m = 1'b1;
        if (r && empty_b) udf_m = 1'b1;
        if (r && !empty_b) void'(model.pop_front());
        if (w && !full_b)  model.push_back(d);
        #1;
        compare_outputs(tag);
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic model_reset();
        model.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    initial begin
        w_en    = 1'b0;
        w_data  = '0;
        r_en    = 1'b0;
        aresetn = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge aclk);
        #1;
        compare_outputs("reset");
        @(negedge aclk);
        aresetn = 1'b1;

        // Ordering.
        step("ord_push", 1'b1, 32'h1111_1111, 1'b0);
        check("ord_head", 64'(r_data), 64'h1111_1111);
        step("ord_push", 1'b1, 32'h2222_2222, 1'b0);
        step("ord_push", 1'b1, 32'h3333_3333, 1'b0);
        step("ord_pop", 1'b0, '0, 1'b1);
        check("ord_second", 64'(r_data), 64'h2222_2222);
        step("ord_pop", 1'b0, '0, 1'b1);
        check("ord_third", 64'(r_data), 64'h3333_3333);
        step("ord_pop", 1'b0, '0, 1'b1);
        check("ord_empty", 64'(empty), 64'd1);

        // Fill and overflow.
        for (int i = 0; i < DEPTH; i++) begin
            step("fill_push", 1'b1, $urandom, 1'b0);
        end
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'(DEPTH));
        step("ovf_push", 1'b1, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step("fill_pop", 1'b0, '0, 1'b1);
        end

        // Wrap: push/pop pairs walk both pointers around several times.
        for (int i = 0; i < 12; i++) begin
            step("wrap_push", 1'b1, 32'hA000_0000 + i, 1'b0);
            step("wrap_pop", 1'b0, '0, 1'b1);
        end

        // Simultaneous push and pop when full: push is dropped.
        for (int i = 0; i < DEPTH; i++) begin
            step("sim_fill", 1'b1, 32'hB000_0000 + i, 1'b0);
        end
        step("sim_full", 1'b1, 32'hCAFE_0001, 1'b1);
        check("sim_full_cnt", 64'(count), 64'(DEPTH - 1));
        while (model.size() != 0) step("sim_drain", 1'b0, '0, 1'b1);

        // Simultaneous when empty: only the push takes effect.
        step("sim_empty", 1'b1, 32'hCAFE_0002, 1'b1);
        check("sim_empty_cnt", 64'(count), 64'd1);
        check("sim_empty_data", 64'(r_data), 64'hCAFE_0002);

        // Simultaneous when partially full: occupancy unchanged.
        step("sim_half_fill", 1'b1, 32'hCAFE_0003, 1'b0);
        step("sim_half", 1'b1, 32'hCAFE_0004, 1'b1);
        check("sim_half_cnt", 64'(count), 64'd2);
        while (model.size() != 0) step("sim_drain", 1'b0, '0, 1'b1);

        // Underflow: pop on empty changes nothing but the sticky flag.
        step("udf_pop", 1'b0, '0, 1'b1);
        step("udf_pop", 1'b0, '0, 1'b1);

        // Asynchronous reset mid-run with three words held.
        for (int i = 0; i < 3; i++) begin
            step("rst_fill", 1'b1, $urandom, 1'b0);
        end
        @(negedge aclk);
        #2;
        aresetn = 1'b0;
        model_reset();
        #1;
        compare_outputs("async_rst");
        @(negedge aclk);
        aresetn = 1'b1;
        step("post_rst", 1'b0, '0, 1'b0);

        // Randomized traffic; bias drifts so occupancy sweeps empty..full.
        for (int i = 0; i < 2000; i++) begin
            int unsigned wp;
            int unsigned rp;
            wp = ((i / 100) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            step("rand", ($urandom_range(0, 99) < wp), $urandom,
                 ($urandom_range(0, 99) < rp));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
